alu: RTL and testbench



---
 rtl/alu_if.sv | 16 +
 rtl/alu.sv | 81 ++++++++
 tb/tb_alu.sv | 139 +++++++++++++
 3 files changed

// File: rtl/alu_if.sv
// Operand/result bundle for the execute-stage ALU.
// The master drives operands and the slave returns registered results.
interface alu_if;
  localparam int unsigned W = 32;

  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   op;
  logic         unsig;
  logic [W-1:0] aluout;
  logic         compout;
  logic         overflow;

  modport master (output a, b, op, unsig, input aluout, compout, overflow);
  modport slave  (input a, b, op, unsig, output aluout, compout, overflow);
endinterface

// File: rtl/alu.sv
// 32-bit registered ALU with one cycle of latency, compare flag and signed overflow.
// Optional macro ALU_SLT_EN turns op 111 into set-less-than; otherwise op 111 yields 0.
module alu (
  input  logic clk,
  input  logic rst_n,
  alu_if.slave bus
);
  localparam int unsigned W = 32;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_NOR = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  logic         sub_c;
  logic [W:0]   addsub_c;
  logic [W:0]   cmpdiff_c;
  logic         lt_c;
  logic [W-1:0] result_c;
  logic         ovf_c;

  // Shared adder: subtract is a + ~b + 1.
  assign sub_c    = (bus.op == OP_SUB) || (bus.op == OP_SLT);
  assign addsub_c = {1'b0, bus.a} + {1'b0, bus.b ^ {W{sub_c}}} + (W+1)'(sub_c);

  // The compare runs every cycle, so it gets its own subtractor independent of op.
  // Unsigned a < b is the borrow out; signed looks at the operand signs first.
  assign cmpdiff_c = {1'b0, bus.a} + {1'b0, ~bus.b} + (W+1)'(1'b1);
  always_comb begin
    lt_c = 1'b0;
    if (bus.unsig)
      lt_c = ~cmpdiff_c[W];
    else if (bus.a[W-1] != bus.b[W-1])
      lt_c = bus.a[W-1];
    else
      lt_c = cmpdiff_c[W-1];
  end

  always_comb begin
    result_c = '0;
    ovf_c    = 1'b0;
    case (bus.op)
      OP_AND: result_c = bus.a & bus.b;
      OP_OR:  result_c = bus.a | bus.b;
      OP_ADD: begin
        result_c = addsub_c[W-1:0];
        ovf_c    = ~bus.unsig && (bus.a[W-1] == bus.b[W-1]) && (addsub_c[W-1] != bus.a[W-1]);
      end
      OP_NOR: result_c = ~(bus.a | bus.b);
      OP_XOR: result_c = bus.a ^ bus.b;
      OP_SUB: begin
        result_c = addsub_c[W-1:0];
        ovf_c    = ~bus.unsig && (bus.a[W-1] != bus.b[W-1]) && (addsub_c[W-1] != bus.a[W-1]);
      end
      OP_SLT: begin
`ifdef ALU_SLT_EN
        result_c = W'(lt_c);
`else
        result_c = '0;
`endif
      end
      default: result_c = '0;
    endcase
  end

  // Output registers; reset clears everything and drops any in-flight result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.aluout   <= '0;
      bus.compout  <= 1'b0;
      bus.overflow <= 1'b0;
    end else begin
      bus.aluout   <= result_c;
      bus.compout  <= lt_c;
      bus.overflow <= ovf_c;
    end
  end
endmodule

// File: tb/tb_alu.sv
// Directed vector bench for alu: table of hand-computed results plus reset/timing sequences.
// Build with ALU_SLT_EN defined or not; SLT expectations follow the macro.
module tb_alu;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  alu_if bus ();

  alu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        unsig;
    logic [31:0] exp_out;
    logic        exp_cmp;
    logic        exp_ovf;
  } vec_t;

`ifdef ALU_SLT_EN
  localparam logic [31:0] SLT_TRUE = 32'h0000_0001;
`else
  localparam logic [31:0] SLT_TRUE = 32'h0000_0000;
`endif

  vec_t vecs [22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic check_outs(input string tag, input logic [31:0] eo, input logic ec, input logic ev);
    check({tag, " aluout"},   bus.aluout, eo);
    check({tag, " compout"},  32'(bus.compout), 32'(ec));
    check({tag, " overflow"}, 32'(bus.overflow), 32'(ev));
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op, input logic u);
    bus.a = a; bus.b = b; bus.op = op; bus.unsig = u;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;

    //        a             b             op      u     aluout        cmp   ovf
    vecs[0]  = '{32'h1,        32'h1,        3'b000, 1'b0, 32'h1,        1'b0, 1'b0};
    vecs[1]  = '{32'h0,        32'h1,        3'b001, 1'b0, 32'h1,        1'b1, 1'b0};
    vecs[2]  = '{32'h1,        32'h1,        3'b100, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[3]  = '{32'h1,        32'h0,        3'b101, 1'b0, 32'h1,        1'b0, 1'b0};
    vecs[4]  = '{32'h1,        32'h1,        3'b010, 1'b0, 32'h2,        1'b0, 1'b0};
    vecs[5]  = '{32'h80000000, 32'h80000000, 3'b010, 1'b0, 32'h0,        1'b0, 1'b1};
    vecs[6]  = '{32'h80000000, 32'h80000000, 3'b010, 1'b1, 32'h0,        1'b0, 1'b0};
    vecs[7]  = '{32'h1,        32'h1,        3'b110, 1'b0, 32'h0,        1'b0, 1'b0};
    vecs[8]  = '{32'h0,        32'h1,        3'b110, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0};
    vecs[9]  = '{32'h7FFFFFFF, 32'hFFFFFFFF, 3'b110, 1'b0, 32'h80000000, 1'b0, 1'b1};
    vecs[10] = '{32'hFFFFFFFF, 32'h1,        3'b110, 1'b0, 32'hFFFFFFFE, 1'b1, 1'b0};
    vecs[11] = '{32'hFFFFFFFF, 32'h1,        3'b110, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[12] = '{32'hFFFFFFFF, 32'h1,        3'b111, 1'b0, SLT_TRUE,     1'b1, 1'b0};
    vecs[13] = '{32'hFFFFFFFF, 32'h1,        3'b111, 1'b1, 32'h0,        1'b0, 1'b0};
    vecs[14] = '{32'h12345678, 32'h9,        3'b011, 1'b0, 32'h0,        1'b0, 1'b0};
    vecs[15] = '{32'h7FFFFFFF, 32'h1,        3'b010, 1'b0, 32'h80000000, 1'b0, 1'b1};
    vecs[16] = '{32'h7FFFFFFF, 32'h1,        3'b010, 1'b1, 32'h80000000, 1'b0, 1'b0};
    vecs[17] = '{32'h5,        32'h5,        3'b000, 1'b1, 32'h5,        1'b0, 1'b0};
    vecs[18] = '{32'hFFFFFFFF, 32'h1,        3'b010, 1'b0, 32'h0,        1'b1, 1'b0};
    vecs[19] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 3'b111, 1'b0, 32'h0,        1'b0, 1'b0};
    vecs[20] = '{32'h80000000, 32'h1,        3'b110, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1};
    vecs[21] = '{32'h1,        32'hFFFFFFFF, 3'b111, 1'b1, SLT_TRUE,     1'b1, 1'b0};

    // Reset with live operands: outputs must be 0 and stay 0 across edges.
    rst_n = 1'b0;
    drive(32'h3, 32'h4, 3'b010, 1'b0);
    #1;
    check_outs("reset", 32'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset held", 32'h0, 1'b0, 1'b0);

    // Release between edges; first edge loads the inputs present there.
    @(negedge clk);
    rst_n = 1'b1;
    drive(32'h3, 32'h4, 3'b010, 1'b0);
    @(posedge clk);
    #1;
    check_outs("first edge", 32'h7, 1'b1, 1'b0);

    // Table applied back to back: one new op per edge, each seen one cycle later.
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].unsig);
      @(posedge clk);
      #1;
      check_outs($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_cmp, vecs[i].exp_ovf);
    end

    // Inputs changing between edges must not disturb the registered outputs.
    @(negedge clk);
    drive(32'h0000_00F0, 32'h0000_000F, 3'b001, 1'b0);
    @(posedge clk);
    #1;
    drive(32'h0, 32'h1, 3'b110, 1'b0);
    #2;
    check_outs("hold between edges", 32'h0000_00FF, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_outs("next edge", 32'hFFFFFFFF, 1'b1, 1'b0);

    // Mid-stream reset drops the in-flight result asynchronously.
    @(negedge clk);
    drive(32'h80000000, 32'h80000000, 3'b010, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    check_outs("async reset", 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_outs("reset discards", 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_outs("after reset", 32'h0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
